// File: rtl/dw_lb_pkg.sv
// Shared types and sizing for the dw_line_buffer ping-pong row buffer.
// Sizes are fixed here so pixel_t and the pointer widths always agree.
package dw_lb_pkg;

    localparam int DW   = 32;
    localparam int POY  = 3;
    localparam int BUFW = 48;
    localparam int LENW = $clog2(BUFW + 1);
    localparam int ROWW = (POY > 1) ? $clog2(POY) : 1;
    localparam int COLW = (BUFW > 1) ? $clog2(BUFW) : 1;

    typedef logic [DW-1:0] pixel_t;
    typedef logic          bank_idx_t;

    // A zero or oversize row length means a full-width row.
    function automatic logic [LENW-1:0] eff_len(input logic [LENW-1:0] row_len);
        logic [LENW-1:0] len;
        if ((row_len == '0) || (row_len > LENW'(BUFW))) begin
            len = LENW'(BUFW);
        end else begin
            len = row_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/dw_lb_bank.sv
// One POY x BUFW pixel bank: single write port, whole-bank synchronous clear,
// and the full array exposed for reading.
module dw_lb_bank
    import dw_lb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [ROWW-1:0] row,
    input  logic [COLW-1:0] col,
    input  pixel_t          din,
    input  logic            clr,
    output pixel_t          data [POY][BUFW]
);

    pixel_t mem_q [POY][BUFW];
    pixel_t mem_d [POY][BUFW];

    // Next bank contents: clear wins; the top never writes and clears one bank together.
    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int r = 0; r < POY; r++) begin
                for (int c = 0; c < BUFW; c++) begin
                    mem_d[r][c] = '0;
                end
            end
        end else if (we) begin
            mem_d[row][col] = din;
        end else begin
            mem_d = mem_q;
        end
    end

    // Bank storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < POY; r++) begin
                for (int c = 0; c < BUFW; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data = mem_q;

endmodule

// File: rtl/dw_line_buffer.sv
// Ping-pong row buffer feeding data_router: one bank fills from the pixel stream
// while the other is read. Optional stats outputs under DW_LINE_BUFFER_STATS_EN.
module dw_line_buffer
    import dw_lb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  pixel_t          in_data,
    input  logic            in_last,
    input  logic [LENW-1:0] row_len,
    output pixel_t          data [POY][BUFW],
    output logic            blk_valid,
    input  logic            blkend
`ifdef DW_LINE_BUFFER_STATS_EN
    ,
    output logic [15:0]     blk_count,
    output logic            blkend_err
`endif
);

    logic [1:0]      full_q, full_d;
    bank_idx_t       wr_bank_q, wr_bank_d;
    bank_idx_t       rd_bank_q, rd_bank_d;
    logic [ROWW-1:0] wr_row_q, wr_row_d;
    logic [COLW-1:0] wr_col_q, wr_col_d;
    logic [LENW-1:0] len_q [2];
    logic [LENW-1:0] len_d [2];

    logic            accept_s, first_s, last_col_s, close_s, release_s;
    logic [LENW-1:0] cur_len_s;
    pixel_t          bank0_data [POY][BUFW];
    pixel_t          bank1_data [POY][BUFW];

    // Gated by rst_n so the source sees no ready while reset is held.
    assign in_ready  = rst_n & ~full_q[wr_bank_q];
    assign blk_valid = full_q[rd_bank_q];

    // Handshake decode; the first pixel of a bank uses the live row_len.
    always_comb begin
        accept_s = in_valid && in_ready;
        first_s  = (wr_row_q == '0) && (wr_col_q == '0);
        if (first_s) begin
            cur_len_s = eff_len(row_len);
        end else begin
            cur_len_s = len_q[wr_bank_q];
        end
        last_col_s = (wr_col_q == COLW'(cur_len_s - LENW'(1)));
        close_s    = accept_s &&
                     (((wr_row_q == ROWW'(POY - 1)) && last_col_s) || in_last);
        release_s  = blkend && full_q[rd_bank_q];
    end

    // Pointer, length and full-flag next state; close and release touch different banks.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        len_d     = len_q;
        if (accept_s) begin
            if (first_s) begin
                len_d[wr_bank_q] = cur_len_s;
            end else begin
                len_d[wr_bank_q] = len_q[wr_bank_q];
            end
            if (close_s) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_row_d          = '0;
                wr_col_d          = '0;
            end else if (last_col_s) begin
                wr_col_d = '0;
                wr_row_d = wr_row_q + ROWW'(1);
            end else begin
                wr_col_d = wr_col_q + COLW'(1);
            end
        end else begin
            wr_bank_d = wr_bank_q;
        end
        if (release_s) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            len_q     <= len_d;
        end
    end

    dw_lb_bank u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept_s && (wr_bank_q == 1'b0)),
        .row   (wr_row_q),
        .col   (wr_col_q),
        .din   (in_data),
        .clr   (release_s && (rd_bank_q == 1'b0)),
        .data  (bank0_data)
    );

    dw_lb_bank u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept_s && (wr_bank_q == 1'b1)),
        .row   (wr_row_q),
        .col   (wr_col_q),
        .din   (in_data),
        .clr   (release_s && (rd_bank_q == 1'b1)),
        .data  (bank1_data)
    );

    // Read-bank select.
    always_comb begin
        if (rd_bank_q) begin
            data = bank1_data;
        end else begin
            data = bank0_data;
        end
    end

`ifdef DW_LINE_BUFFER_STATS_EN
    logic [15:0] blk_count_q, blk_count_d;
    logic        blkend_err_q, blkend_err_d;

    // Release counter wraps naturally; the error flag is sticky until reset.
    always_comb begin
        blk_count_d  = blk_count_q;
        blkend_err_d = blkend_err_q;
        if (release_s) begin
            blk_count_d = blk_count_q + 16'd1;
        end else if (blkend) begin
            blkend_err_d = 1'b1;
        end else begin
            blk_count_d = blk_count_q;
        end
    end

    // Stats registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q  <= 16'd0;
            blkend_err_q <= 1'b0;
        end else begin
            blk_count_q  <= blk_count_d;
            blkend_err_q <= blkend_err_d;
        end
    end

    assign blk_count  = blk_count_q;
    assign blkend_err = blkend_err_q;
`endif

endmodule

// File: tb/tb_dw_line_buffer.sv
// Directed self-checking bench for dw_line_buffer: streams pixel blocks and
// checks handshake, block flags and a table of data probes per block.
module tb_dw_line_buffer;
    import dw_lb_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    pixel_t          in_data;
    logic            in_last;
    logic [LENW-1:0] row_len;
    pixel_t          data [POY][BUFW];
    logic            blk_valid;
    logic            blkend;
`ifdef DW_LINE_BUFFER_STATS_EN
    logic [15:0]     blk_count;
    logic            blkend_err;
`endif

    dw_line_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .row_len   (row_len),
        .data      (data),
        .blk_valid (blk_valid),
        .blkend    (blkend)
`ifdef DW_LINE_BUFFER_STATS_EN
        ,
        .blk_count (blk_count),
        .blkend_err(blkend_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_low = 0;

    typedef struct {
        int          row;
        int          col;
        logic [31:0] exp;
    } probe_t;
    probe_t probes[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add_probe(input int r, input int c, input logic [31:0] v);
        probe_t p;
        p.row = r;
        p.col = c;
        p.exp = v;
        probes.push_back(p);
    endtask

    task automatic run_probes(input string tag);
        foreach (probes[i]) begin
            chk($sformatf("%s_data[%0d][%0d]", tag, probes[i].row, probes[i].col),
                data[probes[i].row][probes[i].col], probes[i].exp);
        end
        probes.delete();
    endtask

    task automatic send(input logic [31:0] v, input logic last);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        if (!in_ready) ready_low++;
        budget = 0;
        while (!in_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stream(input int n, input int base, input logic last_on_final);
        for (int i = 1; i <= n; i++) begin
            send(32'(base + i), last_on_final && (i == n));
        end
    endtask

    task automatic pulse_blkend();
        @(negedge clk);
        blkend = 1'b1;
        @(posedge clk);
        #1;
        blkend = 1'b0;
    endtask

    int nonzero;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        blkend   = 1'b0;
        row_len  = LENW'(48);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_blk_valid", 32'(blk_valid), 32'd0);
        chk("rst_data00", data[0][0], 32'd0);
`ifdef DW_LINE_BUFFER_STATS_EN
        chk("rst_blk_count", 32'(blk_count), 32'd0);
        chk("rst_blkend_err", 32'(blkend_err), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full 3x48 block, no stalls
        ready_low = 0;
        stream(143, 0, 1'b0);
        chk("t1_not_full_at_143", 32'(blk_valid), 32'd0);
        send(32'd144, 1'b0);
        chk("t1_blk_valid", 32'(blk_valid), 32'd1);
        chk("t1_ready_held", 32'(ready_low), 32'd0);
        add_probe(0, 0, 32'd1);
        add_probe(0, 47, 32'd48);
        add_probe(1, 0, 32'd49);
        add_probe(2, 47, 32'd144);
        run_probes("t1");
        pulse_blkend();
        chk("t1_released", 32'(blk_valid), 32'd0);

        // Short rows, row_len=20, into bank 1
        row_len = LENW'(20);
        stream(60, 0, 1'b0);
        chk("t2_blk_valid", 32'(blk_valid), 32'd1);
        add_probe(0, 0, 32'd1);
        add_probe(1, 0, 32'd21);
        add_probe(2, 19, 32'd60);
        add_probe(0, 20, 32'd0);
        add_probe(1, 47, 32'd0);
        add_probe(2, 20, 32'd0);
        run_probes("t2");
        pulse_blkend();

        // Both banks full, then staged release
        row_len = LENW'(48);
        stream(288, 1000, 1'b0);
        chk("t3_ready_low", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_ready_hold", 32'(in_ready), 32'd0);
        chk("t3_blk_valid", 32'(blk_valid), 32'd1);
        chk("t3_bank0_d00", data[0][0], 32'd1001);
        pulse_blkend();
        chk("t3_blk_valid_b1", 32'(blk_valid), 32'd1);
        chk("t3_in_ready", 32'(in_ready), 32'd1);
        chk("t3_bank1_d00", data[0][0], 32'd1145);
        chk("t3_bank1_d247", data[2][47], 32'd1288);
        pulse_blkend();
        chk("t3_empty", 32'(blk_valid), 32'd0);

        // Early close with in_last on pixel 50; bank 0 must have been cleared
        stream(50, 0, 1'b1);
        chk("t4_blk_valid", 32'(blk_valid), 32'd1);
        add_probe(0, 47, 32'd48);
        add_probe(1, 0, 32'd49);
        add_probe(1, 1, 32'd50);
        add_probe(1, 2, 32'd0);
        add_probe(1, 47, 32'd0);
        add_probe(2, 0, 32'd0);
        add_probe(2, 47, 32'd0);
        run_probes("t4");
        pulse_blkend();
`ifdef DW_LINE_BUFFER_STATS_EN
        chk("t4_blk_count", 32'(blk_count), 32'd5);
`endif

        // Stray blkend ignored; single-pixel bank via in_last on first pixel
        pulse_blkend();
        chk("t5_blk_valid", 32'(blk_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
`ifdef DW_LINE_BUFFER_STATS_EN
        chk("t5_blkend_err", 32'(blkend_err), 32'd1);
        chk("t5_blk_count", 32'(blk_count), 32'd5);
`endif
        send(32'd77, 1'b1);
        chk("t5_single_valid", 32'(blk_valid), 32'd1);
        chk("t5_single_d00", data[0][0], 32'd77);
        chk("t5_single_d01", data[0][1], 32'd0);
        pulse_blkend();

        // Reset mid-fill discards everything
        stream(70, 0, 1'b0);
        chk("t6_partial_d00", data[0][0], 32'd1);
        chk("t6_partial_d121", data[1][21], 32'd70);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_blk_valid", 32'(blk_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        nonzero = 0;
        for (int r = 0; r < POY; r++) begin
            for (int c = 0; c < BUFW; c++) begin
                if (data[r][c] != '0) nonzero++;
            end
        end
        chk("t6_rst_nonzero_entries", 32'(nonzero), 32'd0);
`ifdef DW_LINE_BUFFER_STATS_EN
        chk("t6_rst_blk_count", 32'(blk_count), 32'd0);
        chk("t6_rst_blkend_err", 32'(blkend_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        stream(144, 500, 1'b0);
        chk("t6_blk_valid", 32'(blk_valid), 32'd1);
        add_probe(0, 0, 32'd501);
        add_probe(1, 0, 32'd549);
        add_probe(2, 47, 32'd644);
        run_probes("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dw_line_buffer.md
Name: dw_line_buffer

Overview:
Ping-pong row buffer directly upstream of data_router. It accepts a raster pixel stream with a valid/ready handshake. It packs the pixels into blocks of POY rows × BUFW columns and presents a completed block on the data[POY][BUFW] array that data_router consumes. While data_router reads one bank, the other bank fills; data_router's blkend releases the bank it is reading.

Parameters:
DW, 32, pixel width in bits
POY, 3, rows per block (equals data_router POY)
BUFW, 48, columns per row (equals data_router BUFW)
LENW, $clog2(BUFW+1), width of row_len

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous and active-low
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_data  in  DW  pixel, raster order, row-major within block
in_last  in  1  final pixel of the feature map; closes the current bank early
row_len  in  LENW  valid pixels per row; 0 or >BUFW means BUFW
data  out  [POY][BUFW]×DW  contents of the read bank, to data_router.data
blk_valid  out  1  read bank holds a complete block
blkend  in  1  from data_router; releases the read bank

Behaviour:
- State: mem[2][POY][BUFW], full[2], wr_bank, rd_bank, wr_row, wr_col, len_q[2].
- Reset: all mem entries 0, full=0, wr_bank=rd_bank=0, wr_row=wr_col=0, in_ready=0 during reset, blk_valid=0. Reset mid-fill discards everything.
- in_ready = !full[wr_bank] (combinational from registers). No backpressure otherwise.
- First accepted pixel of a bank (wr_row==0 && wr_col==0):
  - latch effective row_len into len_q[wr_bank];
  - row_len must be stable from the first pixel until the bank closes.
- Accepted pixel:
  - mem[wr_bank][wr_row][wr_col] <= in_data.
  - If wr_col == len-1: wr_col=0, wr_row++; otherwise wr_col++.
  - Bank closes when wr_row==POY-1 && wr_col==len-1, or when in_last is high.
- Bank close (registered):
  - full[wr_bank]=1, wr_bank toggles, wr_row=wr_col=0.
  - full is visible the cycle after the closing pixel is accepted.
- Unwritten entries (columns ≥ len, rows after an in_last close) read as 0. This is guaranteed because banks are zeroed on release.
- data = mem[rd_bank] (registered storage, combinational select); blk_valid = full[rd_bank].
- blkend while blk_valid:
  - full[rd_bank]=0 and all entries of mem[rd_bank] cleared to 0 in the same edge;
  - rd_bank toggles;
  - blk_valid for the next bank is visible the following cycle if that bank is full.
- blkend while !blk_valid is ignored.
- Simultaneous close of wr_bank and release of rd_bank (different banks): both take effect.
- Write and clear of the same bank in one cycle cannot occur, since a full bank refuses writes.
- Both banks full: in_ready=0 until a blkend.
- in_last on the first pixel of a bank: that bank closes holding one pixel.
- Steady-state throughput: 1 pixel/cycle while a bank is free.

Optional Feature:
Macro DW_LINE_BUFFER_STATS_EN.
- Defined: adds outputs blk_count (16 bits) and blkend_err (1 bit).
  - blk_count increments on every accepted blkend and wraps at 65535→0.
  - blkend_err is a sticky flag set by blkend while !blk_valid; it is cleared only by reset.
  - Both outputs are 0 at reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dw_lb_pkg holds:
  - pixel_t (logic [DW-1:0]);
  - bank_idx_t (1 bit);
  - the function eff_len(row_len) mapping 0 or >BUFW to BUFW.
- Sub-module dw_lb_bank: one POY×BUFW register bank with a write port (we, row, col, din), a synchronous clear, and a full-array read. The top instantiates it twice and holds the FSM, pointers and full flags.

Test Plan:
- Reset, then stream 144 pixels, values 1..144, row_len=48, no stalls → blk_valid rises the cycle after pixel 144; data[0][0]=1, data[2][47]=144; in_ready stays 1.
- row_len=20, stream 60 pixels → bank closes after pixel 60; data[1][0]=21; data[r][20..47]=0 for all rows.
- Fill both banks (288 pixels), hold blkend=0 → in_ready=0 from the cycle after pixel 288. Pulse blkend → rd_bank cleared to 0, blk_valid stays 1 (second bank), in_ready=1 the next cycle.
- Stream 50 pixels with in_last on pixel 50, row_len=48 → blk_valid=1; data[1][1]=50; data[1][2..47] and row 2 all zero.
- blkend pulse with blk_valid=0 → no state change. With DW_LINE_BUFFER_STATS_EN: blkend_err=1 and blk_count unchanged; after three legal releases blk_count=3.
- Assert rst_n=0 mid-fill after 70 pixels → blk_valid=0, all data zero. After release, a fresh 144-pixel stream fills bank 0 from row 0, col 0.
